// File: rtl/car_pkg.sv
// Shared types and default timing for the seat-belt/door chime controller.
package car_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_BEEP_ON,
        ST_BEEP_OFF,
        ST_LAMP_ONLY
    } chime_state_e;

    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int DELAY_CYC_DEF    = 8;
    localparam int ON_CYC_DEF       = 4;
    localparam int OFF_CYC_DEF      = 4;
    localparam int MAX_BEEPS_DEF    = 6;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a symmetric level debouncer: the output
// follows the input only after DEBOUNCE_CYC consecutive agreeing samples.
module sync_debounce
    import car_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic Clk,
    input  logic RstN,
    input  logic In,
    output logic Out
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // Any sample agreeing with the current output restarts the run count.
    always_comb begin
        sync1_d = In;
        sync2_d = sync1_q;
        cnt_d   = '0;
        out_d   = out_q;
        if (sync2_q != out_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                out_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign Out = out_q;

endmodule

// File: rtl/car_chime.sv
// Warning chime sequencer: grace delay, a bounded train of beeps, then lamp only.
//   state        | meaning
//   ST_IDLE      | no request, all outputs low
//   ST_DELAY     | request seen, grace period before the first beep
//   ST_BEEP_ON   | buzzer driven for ON_CYC cycles
//   ST_BEEP_OFF  | buzzer silent for OFF_CYC cycles between beeps
//   ST_LAMP_ONLY | beeps exhausted or muted; lamp stays on until request clears
module car_chime
    import car_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int DELAY_CYC    = DELAY_CYC_DEF,
    parameter int ON_CYC       = ON_CYC_DEF,
    parameter int OFF_CYC      = OFF_CYC_DEF,
    parameter int MAX_BEEPS    = MAX_BEEPS_DEF
) (
    input  logic                           Clk,
    input  logic                           RstN,
    input  logic                           Alarm,
    input  logic                           Mute,
    output logic                           Buzzer,
    output logic                           Lamp,
    output logic [$clog2(MAX_BEEPS+1)-1:0] BeepCnt,
    output logic                           Active
);

    localparam int TW = $clog2(max3(DELAY_CYC, ON_CYC, OFF_CYC) + 1);
    localparam int BW = $clog2(MAX_BEEPS + 1);

    chime_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          buzzer_q, buzzer_d;
    logic          lamp_q, lamp_d;
    logic          active_q, active_d;
    logic          req;
    logic          timer_done;

    sync_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_sync_debounce (
        .Clk (Clk),
        .RstN(RstN),
        .In  (Alarm),
        .Out (req)
    );

    // Timer is loaded with the full cycle count; the last cycle sees 1.
    assign timer_done = (timer_q == TW'(1));

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        beep_cnt_d = beep_cnt_q;

        if (state_q != ST_IDLE && !req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_DELAY;
                        timer_d = TW'(DELAY_CYC);
                    end
                end
                ST_DELAY: begin
                    if (Mute) begin
                        state_d = ST_LAMP_ONLY;
                    end else if (timer_done) begin
                        state_d    = ST_BEEP_ON;
                        beep_cnt_d = beep_cnt_q + 1'b1;
                        timer_d    = TW'(ON_CYC);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_BEEP_ON: begin
                    if (Mute) begin
                        state_d = ST_LAMP_ONLY;
                    end else if (timer_done) begin
                        state_d = ST_BEEP_OFF;
                        timer_d = TW'(OFF_CYC);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_BEEP_OFF: begin
                    if (Mute) begin
                        state_d = ST_LAMP_ONLY;
                    end else if (timer_done) begin
                        if (beep_cnt_q == BW'(MAX_BEEPS)) begin
                            state_d = ST_LAMP_ONLY;
                        end else begin
                            state_d    = ST_BEEP_ON;
                            beep_cnt_d = beep_cnt_q + 1'b1;
                            timer_d    = TW'(ON_CYC);
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_LAMP_ONLY: begin
                    state_d = ST_LAMP_ONLY;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (state_d == ST_IDLE) begin
            timer_d    = '0;
            beep_cnt_d = '0;
        end

        // Outputs follow the next state so they change on the transition edge.
        buzzer_d = (state_d == ST_BEEP_ON);
        lamp_d   = (state_d != ST_IDLE);
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            beep_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            lamp_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            beep_cnt_q <= beep_cnt_d;
            buzzer_q   <= buzzer_d;
            lamp_q     <= lamp_d;
            active_q   <= active_d;
        end
    end

    assign Buzzer  = buzzer_q;
    assign Lamp    = lamp_q;
    assign BeepCnt = beep_cnt_q;
    assign Active  = active_q;

endmodule

// File: tb/tb_car_chime.sv
// Self-checking bench for car_chime against an episode-time reference model.
module tb_car_chime;

    localparam int DB  = 4;
    localparam int DL  = 8;
    localparam int ON  = 4;
    localparam int OFF = 4;
    localparam int MB  = 6;
    localparam int PER = ON + OFF;

    logic       Clk = 1'b0;
    logic       RstN;
    logic       Alarm;
    logic       Mute;
    logic       Buzzer;
    logic       Lamp;
    logic       Active;
    logic [2:0] BeepCnt;

    car_chime #(
        .DEBOUNCE_CYC(DB),
        .DELAY_CYC   (DL),
        .ON_CYC      (ON),
        .OFF_CYC     (OFF),
        .MAX_BEEPS   (MB)
    ) dut (
        .Clk    (Clk),
        .RstN   (RstN),
        .Alarm  (Alarm),
        .Mute   (Mute),
        .Buzzer (Buzzer),
        .Lamp   (Lamp),
        .BeepCnt(BeepCnt),
        .Active (Active)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: alarm sample history, debounced request, and for the
    // current episode the number of edges elapsed since it started.
    bit ahist[$];
    bit m_req;
    bit m_active;
    bit m_muted;
    int m_t;
    int m_frozen;

    function automatic int cnt_at(input int t);
        if (t < DL) return 0;
        if ((t - DL) / PER >= MB) return MB;
        return (t - DL) / PER + 1;
    endfunction

    function automatic bit buzz_at(input int t);
        if (t < DL) return 1'b0;
        if ((t - DL) / PER >= MB) return 1'b0;
        return ((t - DL) % PER) < ON;
    endfunction

    function automatic bit silent_at(input int t);
        return (t >= DL) && ((t - DL) / PER >= MB);
    endfunction

    function automatic bit exp_buzz();
        return m_active && !m_muted && buzz_at(m_t);
    endfunction

    function automatic logic [2:0] exp_cnt();
        if (!m_active) return 3'd0;
        if (m_muted) return 3'(m_frozen);
        return 3'(cnt_at(m_t));
    endfunction

    task automatic model_reset();
        ahist.delete();
        m_req    = 1'b0;
        m_active = 1'b0;
        m_muted  = 1'b0;
        m_t      = 0;
        m_frozen = 0;
    endtask

    task automatic model_edge(input bit a, input bit m);
        bit old_req;
        bit all_diff;
        old_req = m_req;
        if (!m_active) begin
            if (old_req) begin
                m_active = 1'b1;
                m_t      = 0;
                m_muted  = 1'b0;
            end
        end else if (!old_req) begin
            m_active = 1'b0;
        end else if (m && !m_muted && !silent_at(m_t)) begin
            m_muted  = 1'b1;
            m_frozen = cnt_at(m_t);
        end else if (!m_muted) begin
            m_t++;
        end
        // The debouncer sees the alarm value sampled two edges earlier.
        ahist.push_back(a);
        if (ahist.size() >= DB + 2) begin
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) begin
                if (ahist[ahist.size() - 3 - i] == m_req) all_diff = 1'b0;
            end
            if (all_diff) m_req = !m_req;
        end
        if (ahist.size() > 16) void'(ahist.pop_front());
    endtask

    task automatic tick(input bit a, input bit m);
        Alarm = a;
        Mute  = m;
        @(posedge Clk);
        model_edge(a, m);
        #1;
    endtask

    task automatic test_reset();
        RstN = 1'b1;
        #1 RstN = 1'b0;
        #2;
        checks++;
        if ({Buzzer, Lamp, Active, BeepCnt} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async got buz=%b lamp=%b act=%b cnt=%0d want all 0", Buzzer, Lamp, Active, BeepCnt);
        end
        model_reset();
        @(negedge Clk);
        RstN = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick(1'b0, n == 2);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got buz=%b lamp=%b act=%b cnt=%0d want all 0", n, Buzzer, Lamp, Active, BeepCnt);
            end
        end
    endtask

    task automatic test_long_alarm();
        int first_on = 0;
        int rises    = 0;
        bit prev     = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL long_alarm edge=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
            if (Buzzer === 1'b1 && !prev) begin
                rises++;
                if (first_on == 0) first_on = n;
            end
            prev = (Buzzer === 1'b1);
        end
        checks++;
        if (first_on != 15) begin
            errors++;
            $display("FAIL first_beep_edge got %0d want 15", first_on);
        end
        checks++;
        if (rises != MB) begin
            errors++;
            $display("FAIL beep_count_total got %0d want %0d", rises, MB);
        end
        checks++;
        if ({Lamp, Buzzer, BeepCnt} !== {1'b1, 1'b0, 3'(MB)}) begin
            errors++;
            $display("FAIL lamp_only_final got lamp=%b buz=%b cnt=%0d want lamp=1 buz=0 cnt=%0d", Lamp, Buzzer, BeepCnt, MB);
        end
        for (int n = 0; n < 10; n++) begin
            tick(1'b0, 1'b0);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL long_release cyc=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
        end
    endtask

    task automatic test_short_pulse();
        bit any_out = 1'b0;
        for (int n = 0; n < 23; n++) begin
            tick(n < 3, 1'b0);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL short_pulse cyc=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
            if (Buzzer !== 1'b0 || Lamp !== 1'b0 || Active !== 1'b0) any_out = 1'b1;
        end
        checks++;
        if (any_out) begin
            errors++;
            $display("FAIL short_pulse_quiet got outputs active=1 want 0");
        end
    endtask

    task automatic test_drop_in_off();
        bit reached = 1'b0;
        int idle_at = 0;
        int rises   = 0;
        bit prev;
        // Drop the alarm so the debounced request falls during the second gap.
        for (int n = 0; n < 60 && !reached; n++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL drop_rise cyc=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
            if (m_active && (m_t - DL) == PER + 1) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL drop_reach got no second beep want second beep within 60 cycles");
        end
        prev = (Buzzer === 1'b1);
        for (int n = 1; n <= 15; n++) begin
            tick(1'b0, 1'b0);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL drop_fall edge=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
            if (Active === 1'b0 && idle_at == 0) idle_at = n;
            if (Buzzer === 1'b1 && !prev) rises++;
            prev = (Buzzer === 1'b1);
        end
        // 2 synchronizer + 4 debounce + 1 FSM edge
        checks++;
        if (idle_at != 7) begin
            errors++;
            $display("FAIL drop_idle_edge got %0d want 7", idle_at);
        end
        checks++;
        if (rises != 0 || Lamp !== 1'b0 || BeepCnt !== 3'd0) begin
            errors++;
            $display("FAIL drop_after got rises=%0d lamp=%b cnt=%0d want rises=0 lamp=0 cnt=0", rises, Lamp, BeepCnt);
        end
    endtask

    task automatic test_mute();
        bit reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            tick(1'b1, 1'b0);
            if (m_active && (m_t - DL) == 2) reached = 1'b1;
        end
        checks++;
        if (!reached || Buzzer !== 1'b1) begin
            errors++;
            $display("FAIL mute_setup got reached=%b buz=%b want reached=1 buz=1", reached, Buzzer);
        end
        tick(1'b1, 1'b1);
        checks++;
        if ({Buzzer, Lamp, BeepCnt} !== {1'b0, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL mute_edge got buz=%b lamp=%b cnt=%0d want buz=0 lamp=1 cnt=1", Buzzer, Lamp, BeepCnt);
        end
        for (int n = 0; n < 30; n++) begin
            tick(1'b1, n == 10);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL mute_hold cyc=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
        end
        checks++;
        if ({Buzzer, Lamp, BeepCnt} !== {1'b0, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL mute_final got buz=%b lamp=%b cnt=%0d want buz=0 lamp=1 cnt=1", Buzzer, Lamp, BeepCnt);
        end
        for (int n = 0; n < 10; n++) tick(1'b0, 1'b0);
        checks++;
        if ({Lamp, Active, BeepCnt} !== 5'b0) begin
            errors++;
            $display("FAIL mute_release got lamp=%b act=%b cnt=%0d want 0", Lamp, Active, BeepCnt);
        end
    endtask

    task automatic test_reset_mid();
        int first_on = 0;
        for (int n = 0; n < 40 && !(m_active && m_t == DL + 1); n++) tick(1'b1, 1'b0);
        checks++;
        if (Buzzer !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup got buz=%b want 1", Buzzer);
        end
        #2 RstN = 1'b0;
        #1;
        checks++;
        if ({Buzzer, Lamp, Active, BeepCnt} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_async got buz=%b lamp=%b act=%b cnt=%0d want all 0", Buzzer, Lamp, Active, BeepCnt);
        end
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        RstN = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL rstmid_again edge=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
            if (Buzzer === 1'b1 && first_on == 0) first_on = n;
        end
        checks++;
        if (first_on != 15) begin
            errors++;
            $display("FAIL rstmid_first_beep got %0d want 15", first_on);
        end
        for (int n = 0; n < 10; n++) tick(1'b0, 1'b0);
    endtask

    task automatic test_delay_drop();
        bit any_buz  = 1'b0;
        bit saw_both = 1'b0;
        bit m;
        for (int n = 0; n < 20 && !m_active; n++) tick(1'b1, 1'b0);
        for (int n = 0; n < 3; n++) tick(1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            // Pulse Mute on exactly the edge where the request is seen low.
            m = !m_req && m_active;
            tick(1'b0, m);
            if (Buzzer !== 1'b0) any_buz = 1'b1;
            if (m) begin
                saw_both = 1'b1;
                checks++;
                if ({Active, Lamp, BeepCnt} !== 5'b0) begin
                    errors++;
                    $display("FAIL req_vs_mute got act=%b lamp=%b cnt=%0d want all 0", Active, Lamp, BeepCnt);
                end
            end
        end
        checks++;
        if (!saw_both || any_buz) begin
            errors++;
            $display("FAIL delay_drop got coincide=%b buzzed=%b want coincide=1 buzzed=0", saw_both, any_buz);
        end
    endtask

    task automatic test_random();
        bit a    = 1'b0;
        bit m;
        int hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    a    = !a;
                    hold = $urandom_range(1, 3);
                end else begin
                    a    = ($urandom_range(0, 1) == 1);
                    hold = $urandom_range(5, 80);
                end
            end
            hold--;
            m = ($urandom_range(0, 24) == 0);
            tick(a, m);
            checks++;
            if ({Buzzer, Lamp, Active, BeepCnt} !== {exp_buzz(), m_active, m_active, exp_cnt()}) begin
                errors++;
                $display("FAIL random cyc=%0d got buz=%b lamp=%b act=%b cnt=%0d want buz=%b lamp=%b act=%b cnt=%0d",
                         n, Buzzer, Lamp, Active, BeepCnt, exp_buzz(), m_active, m_active, exp_cnt());
            end
        end
    endtask

    initial begin
        RstN  = 1'b1;
        Alarm = 1'b0;
        Mute  = 1'b0;
        model_reset();
        test_reset();
        test_long_alarm();
        test_short_pulse();
        test_drop_in_off();
        test_mute();
        test_reset_mid();
        test_delay_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
